// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the 8-bit snooping bus and the MSI cache controller.
// Message layout is {op[7:6], addr[5:4], value[3:0]}.
package snoop_bus_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RM   = 2'b01;
    localparam logic [1:0] WB   = 2'b10;
    localparam logic [1:0] WM   = 2'b11;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 6;
    localparam int ADDR_HI = 5;
    localparam int ADDR_LO = 4;
    localparam int VAL_HI  = 3;
    localparam int VAL_LO  = 0;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_WB    = 3'd2,
        S_RM    = 3'd3,
        S_FILL  = 3'd4,
        S_WM    = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0] msi;
        logic       tag;
        logic [3:0] data;
    } line_t;

    typedef struct packed {
        logic [OP_HI-OP_LO:0]     op;
        logic [ADDR_HI-ADDR_LO:0] addr;
        logic [VAL_HI-VAL_LO:0]   value;
    } bus_msg_t;

endpackage

// File: rtl/cache_line_array.sv
// Two-entry direct-mapped line store with snoop-driven state changes.
// FSM writes take priority over snoop updates on the same line.
module cache_line_array
    import snoop_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  lk_addr,
    output line_t       lk_line,
    output logic        lk_hit,
    output logic        lk_victim_m,
    output logic        lk_snoop_kill,
    input  logic [1:0]  snoop_op,
    input  logic [1:0]  snoop_addr,
    input  logic        wr_en,
    input  logic        wr_idx,
    input  line_t       wr_line,
    output line_t [1:0] lines,
    output logic [1:0]  pend,
    output logic [1:0]  pend_to_i
);

    for (genvar i = 0; i < 2; i++) begin : g_line
        line_t line_r;
        logic  pend_r;
        logic  to_i_r;
        logic  snp_match;
        logic  snp_m_req;
        logic  snp_m_wm;

        assign snp_match = (snoop_op != IDLE) && (line_r.msi != MSI_I) &&
                           (snoop_addr == {line_r.tag, 1'(i)});
        assign snp_m_req = snp_match && (line_r.msi == MSI_M) && (snoop_op != WB);
        assign snp_m_wm  = snp_m_req && (snoop_op == WM);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                line_r <= '0;
                pend_r <= 1'b0;
                to_i_r <= 1'b0;
            end else if (wr_en && wr_idx == 1'(i)) begin
                line_r <= wr_line;
                // a line still held in M keeps any flush owed to another master
                pend_r <= (wr_line.msi == MSI_M) && (pend_r || snp_m_req);
                to_i_r <= (wr_line.msi == MSI_M) && (to_i_r || snp_m_wm);
            end else if (snp_match) begin
                if (snoop_op == WM && line_r.msi == MSI_S)
                    line_r.msi <= MSI_I;
                if (snp_m_req)
                    pend_r <= 1'b1;
                if (snp_m_wm)
                    to_i_r <= 1'b1;
            end
        end

        assign lines[i]     = line_r;
        assign pend[i]      = pend_r;
        assign pend_to_i[i] = to_i_r;
    end

    assign lk_line       = lines[lk_addr[0]];
    assign lk_hit        = (lk_line.msi != MSI_I) && (lk_line.tag == lk_addr[1]);
    assign lk_victim_m   = (lk_line.msi == MSI_M) && !lk_hit;
    assign lk_snoop_kill = (snoop_op == WM) && (snoop_addr == lk_addr) &&
                           (lk_line.msi == MSI_S) && (lk_line.tag == lk_addr[1]);

endmodule

// File: rtl/snoop_cache_ctrl.sv
// Bus-initiator MSI cache controller: 2-line direct-mapped cache over a 4-word memory.
// Serves CPU reads/writes, issues RM/WB/WM messages and services snoop flushes.
module snoop_cache_ctrl
    import snoop_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [1:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic       cpu_ready,
    output logic [3:0] cpu_rdata,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [7:0] bus_out,
    input  logic [3:0] mem_q,
    input  logic [7:0] snoop_in
);

    state_t      state, state_nx;
    logic        req_we;
    logic [1:0]  req_addr;
    logic [3:0]  req_wdata;
    logic        fill_wait, fill_nx;
    logic        fl_idx;
    bus_msg_t    bus_q, bus_nx;

    logic [1:0]  lk_addr;
    line_t       lk_line;
    logic        lk_hit, lk_victim_m, lk_kill;
    line_t [1:0] lines;
    line_t       fl_line;
    logic [1:0]  pend, pend_to_i;
    logic        wr_en, wr_idx;
    line_t       wr_line;
    logic        accept;
    logic        snoop_value_unused;

    assign snoop_value_unused = ^snoop_in[VAL_HI:VAL_LO];
    assign lk_addr = (state == S_IDLE) ? cpu_addr : req_addr;
    assign fl_line = lines[fl_idx];
    assign accept  = (state == S_IDLE) && !(|pend) && cpu_req && !cpu_ready;

    cache_line_array u_lines (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_addr       (lk_addr),
        .lk_line       (lk_line),
        .lk_hit        (lk_hit),
        .lk_victim_m   (lk_victim_m),
        .lk_snoop_kill (lk_kill),
        .snoop_op      (snoop_in[OP_HI:OP_LO]),
        .snoop_addr    (snoop_in[ADDR_HI:ADDR_LO]),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_line       (wr_line),
        .lines         (lines),
        .pend          (pend),
        .pend_to_i     (pend_to_i)
    );

    always_comb begin
        state_nx = state;
        bus_nx   = '0;
        fill_nx  = fill_wait;
        wr_en    = 1'b0;
        wr_idx   = req_addr[0];
        wr_line  = lk_line;
        case (state)
            S_IDLE: begin
                if (|pend) begin
                    state_nx = S_FLUSH;
                end else if (cpu_req && !cpu_ready) begin
                    if (lk_hit && !cpu_we) begin
                        state_nx = S_DONE;
                    end else if (lk_hit && lk_line.msi == MSI_M) begin
                        wr_en        = 1'b1;
                        wr_idx       = cpu_addr[0];
                        wr_line.data = cpu_wdata;
                        state_nx     = S_DONE;
                    end else if (lk_hit) begin
                        state_nx = S_WM;
                    end else if (lk_victim_m) begin
                        state_nx = S_WB;
                    end else begin
                        state_nx = S_RM;
                    end
                end
            end
            S_FLUSH: begin
                if (bus_gnt) begin
                    bus_nx      = '{op: WB, addr: {fl_line.tag, fl_idx}, value: fl_line.data};
                    wr_en       = 1'b1;
                    wr_idx      = fl_idx;
                    wr_line     = fl_line;
                    wr_line.msi = pend_to_i[fl_idx] ? MSI_I : MSI_S;
                    state_nx    = S_IDLE;
                end
            end
            S_WB: begin
                if (bus_gnt) begin
                    bus_nx      = '{op: WB, addr: {lk_line.tag, req_addr[0]}, value: lk_line.data};
                    wr_en       = 1'b1;
                    wr_line.msi = MSI_I;
                    state_nx    = S_RM;
                end
            end
            S_RM: begin
                if (bus_gnt) begin
                    bus_nx   = '{op: RM, addr: req_addr, value: 4'h0};
                    fill_nx  = 1'b1;
                    state_nx = S_FILL;
                end
            end
            S_FILL: begin
                // memory answers one cycle after the RM is on the bus
                if (fill_wait) begin
                    fill_nx = 1'b0;
                end else begin
                    wr_en    = 1'b1;
                    wr_line  = '{msi: MSI_S, tag: req_addr[1], data: mem_q};
                    state_nx = req_we ? S_WM : S_DONE;
                end
            end
            S_WM: begin
                // losing the S copy before grant turns the upgrade into a full miss
                if (lk_kill || !lk_hit) begin
                    state_nx = S_RM;
                end else if (bus_gnt) begin
                    bus_nx   = '{op: WM, addr: req_addr, value: 4'h0};
                    wr_en    = 1'b1;
                    wr_line  = '{msi: MSI_M, tag: req_addr[1], data: req_wdata};
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_we    <= 1'b0;
            req_addr  <= 2'b00;
            req_wdata <= 4'h0;
            fill_wait <= 1'b0;
            fl_idx    <= 1'b0;
            bus_q     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= 4'h0;
        end else begin
            state     <= state_nx;
            fill_wait <= fill_nx;
            bus_q     <= bus_nx;
            cpu_ready <= (state == S_DONE);
            if (state == S_IDLE && (|pend))
                fl_idx <= ~pend[0];
            if (accept) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
            if (state == S_DONE)
                cpu_rdata <= req_we ? req_wdata : lk_line.data;
        end
    end

    assign bus_req = (state == S_FLUSH) || (state == S_WB) || (state == S_RM) ||
                     ((state == S_WM) && !(lk_kill || !lk_hit));
    assign bus_out = bus_q;

endmodule
